// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding and parity type constants,
// common to the transmit and receive paths.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART TX data serializer: LSB-first shift register with bit counter.
// next_bit_o is the bit that will be on the line after this edge.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  next_bit_o,
    output logic                  ser_done_o
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sh_d  = data_i;
            cnt_d = '0;
        end else if (shift_i) begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign next_bit_o = sh_d[0];
    assign ser_done_o = (cnt_q == CW'(DATA_WIDTH - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter top: frame FSM, bit prescaler, parity and line mux.
// Line and BUSY are registered from the next state so accept shows next cycle.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          par_en_q, par_en_d;
    logic          par_bit_q, par_bit_d;
    logic          adv, accept, shift;
    logic          next_bit, ser_done;

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .CLK       (CLK),
        .RST       (RST),
        .load_i    (accept),
        .shift_i   (shift),
        .data_i    (P_DATA),
        .next_bit_o(next_bit),
        .ser_done_o(ser_done)
    );

    always_comb begin
        adv     = (pre_q == PRE_LAST);
        accept  = 1'b0;
        shift   = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (DATA_VALID) begin
                    accept  = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (adv) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (adv) begin
                    if (ser_done)
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    else
                        shift = 1'b1;
                end
            end
            ST_PARITY: begin
                if (adv) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Last stop cycle doubles as an accept slot for back-to-back frames
                if (adv) begin
                    if (DATA_VALID) begin
                        accept  = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_IDLE || state_d == ST_IDLE || adv)
            pre_d = '0;
        else
            pre_d = pre_q + 1'b1;

        par_en_d  = accept ? PAR_EN : par_en_q;
        par_bit_d = par_bit_q;
        if (accept)
            par_bit_d = (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;

        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = next_bit;
            ST_PARITY: tx_d = par_bit_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: PRESCALE=1 and PRESCALE=4 instances
// compared cycle by cycle against a frame-level line model.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] pd  = 8'h00;
    logic       dv  = 1'b0;
    logic       pe  = 1'b0;
    logic       pt  = 1'b0;
    int         sel = 1;

    logic dv1, dv4, tx1, bz1, tx4, bz4;

    int total = 0;
    int bad   = 0;

    logic exp_tx[$];
    logic exp_bz[$];

    assign dv1 = dv & (sel == 1);
    assign dv4 = dv & (sel == 4);

    always #5 CLK = ~CLK;

    uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(1)) dut1 (
        .CLK(CLK), .RST(RST), .P_DATA(pd), .DATA_VALID(dv1),
        .PAR_EN(pe), .PAR_TYP(pt), .TX_OUT(tx1), .BUSY(bz1)
    );

    uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(4)) dut4 (
        .CLK(CLK), .RST(RST), .P_DATA(pd), .DATA_VALID(dv4),
        .PAR_EN(pe), .PAR_TYP(pt), .TX_OUT(tx4), .BUSY(bz4)
    );

    function automatic logic get_tx();
        return (sel == 1) ? tx1 : tx4;
    endfunction

    function automatic logic get_bz();
        return (sel == 1) ? bz1 : bz4;
    endfunction

    // Line model: start 0, data LSB first, optional parity, stop 1; each bit p cycles
    function automatic void push_frame(logic [7:0] d, logic e, logic t, int p);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (e) bits.push_back(t ? ~^d : ^d);
        bits.push_back(1'b1);
        foreach (bits[i])
            for (int r = 0; r < p; r++) begin
                exp_tx.push_back(bits[i]);
                exp_bz.push_back(1'b1);
            end
    endfunction

    function automatic void push_idle(int n);
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(1'b1);
            exp_bz.push_back(1'b0);
        end
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        #2 RST = 1'b0;
        #1;
        total++;
        if ({tx1, bz1, tx4, bz4} !== 4'b1010) begin
            bad++;
            $display("FAIL reset_async got=%b exp=1010", {tx1, bz1, tx4, bz4});
        end
        repeat (2) @(negedge CLK);
        total++;
        if ({tx1, bz1, tx4, bz4} !== 4'b1010) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=1010", {tx1, bz1, tx4, bz4});
        end
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        total++;
        if ({tx1, bz1, tx4, bz4} !== 4'b1010) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=1010", {tx1, bz1, tx4, bz4});
        end
    endtask

    task automatic test_frames();
        logic [7:0] d;
        logic       e, t;
        int         p, nb;
        for (int n = 0; n < 12; n++) begin
            if (n == 0) begin d = 8'hA5; e = 0; t = 0; p = 1; end
            else if (n == 1) begin d = 8'hA5; e = 1; t = 0; p = 1; end
            else if (n == 2) begin d = 8'hA5; e = 1; t = 1; p = 1; end
            else if (n == 3) begin d = 8'h3C; e = 0; t = 0; p = 4; end
            else begin
                d = 8'($urandom);
                e = 1'($urandom);
                t = 1'($urandom);
                p = ($urandom_range(0, 1) == 1) ? 4 : 1;
            end
            sel = p;
            exp_tx.delete();
            exp_bz.delete();
            push_frame(d, e, t, p);
            push_idle(3);
            nb = 0;
            @(negedge CLK);
            pd = d; pe = e; pt = t; dv = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            dv = 1'b0;
            pd = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom);
            for (int k = 0; k < exp_tx.size(); k++) begin
                total++;
                if (get_tx() !== exp_tx[k]) begin
                    bad++;
                    $display("FAIL frame%0d cyc%0d tx got=%b exp=%b", n, k, get_tx(), exp_tx[k]);
                end
                total++;
                if (get_bz() !== exp_bz[k]) begin
                    bad++;
                    $display("FAIL frame%0d cyc%0d busy got=%b exp=%b", n, k, get_bz(), exp_bz[k]);
                end
                if (get_bz() === 1'b1) nb++;
                @(negedge CLK);
            end
            total++;
            if (nb != (10 + int'(e)) * p) begin
                bad++;
                $display("FAIL frame%0d busy_len got=%0d exp=%0d", n, nb, (10 + int'(e)) * p);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1, d2;
        logic       e1, t1, e2, t2;
        int         p, len1;
        for (int n = 0; n < 4; n++) begin
            if (n == 0) begin
                d1 = 8'h01; d2 = 8'h80; e1 = 0; t1 = 0; e2 = 0; t2 = 0; p = 1;
            end else begin
                d1 = 8'($urandom); d2 = 8'($urandom);
                e1 = 1'($urandom); t1 = 1'($urandom);
                e2 = 1'($urandom); t2 = 1'($urandom);
                p = (n == 1) ? 4 : 1;
            end
            sel = p;
            exp_tx.delete();
            exp_bz.delete();
            push_frame(d1, e1, t1, p);
            push_frame(d2, e2, t2, p);
            push_idle(3);
            len1 = (10 + int'(e1)) * p;
            @(negedge CLK);
            pd = d1; pe = e1; pt = t1; dv = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            pd = d2; pe = e2; pt = t2;
            for (int k = 0; k < exp_tx.size(); k++) begin
                if (k == len1) dv = 1'b0;
                total++;
                if (get_tx() !== exp_tx[k]) begin
                    bad++;
                    $display("FAIL b2b%0d cyc%0d tx got=%b exp=%b", n, k, get_tx(), exp_tx[k]);
                end
                total++;
                if (get_bz() !== exp_bz[k]) begin
                    bad++;
                    $display("FAIL b2b%0d cyc%0d busy got=%b exp=%b", n, k, get_bz(), exp_bz[k]);
                end
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_ignore();
        logic [7:0] d;
        logic       e, t;
        int         p;
        for (int n = 0; n < 3; n++) begin
            if (n == 0) begin d = 8'h00; e = 0; t = 0; p = 1; end
            else begin
                d = 8'($urandom); e = 1'($urandom); t = 1'($urandom);
                p = (n == 1) ? 4 : 1;
            end
            sel = p;
            exp_tx.delete();
            exp_bz.delete();
            push_frame(d, e, t, p);
            push_idle(3);
            @(negedge CLK);
            pd = d; pe = e; pt = t; dv = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            dv = 1'b0;
            for (int k = 0; k < exp_tx.size(); k++) begin
                if (k == 2 * p) begin
                    pd = 8'hFF; pe = ~e; pt = ~t; dv = 1'b1;
                end
                if (k == 3 * p) dv = 1'b0;
                total++;
                if (get_tx() !== exp_tx[k]) begin
                    bad++;
                    $display("FAIL ignore%0d cyc%0d tx got=%b exp=%b", n, k, get_tx(), exp_tx[k]);
                end
                total++;
                if (get_bz() !== exp_bz[k]) begin
                    bad++;
                    $display("FAIL ignore%0d cyc%0d busy got=%b exp=%b", n, k, get_bz(), exp_bz[k]);
                end
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        sel = 1;
        d = 8'($urandom) & 8'hF7;
        @(negedge CLK);
        pd = d; pe = 1'b0; pt = 1'b0; dv = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        dv = 1'b0;
        repeat (4) @(negedge CLK);
        total++;
        if (tx1 !== 1'b0 || bz1 !== 1'b1) begin
            bad++;
            $display("FAIL mid_bit3 got tx=%b busy=%b exp tx=0 busy=1", tx1, bz1);
        end
        RST = 1'b0;
        #1;
        total++;
        if (tx1 !== 1'b1 || bz1 !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got tx=%b busy=%b exp tx=1 busy=0", tx1, bz1);
        end
        @(negedge CLK);
        RST = 1'b1;
        exp_tx.delete();
        exp_bz.delete();
        push_frame(8'h5A, 1'b0, 1'b0, 1);
        push_idle(3);
        @(negedge CLK);
        pd = 8'h5A; dv = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        dv = 1'b0;
        for (int k = 0; k < exp_tx.size(); k++) begin
            total++;
            if (tx1 !== exp_tx[k] || bz1 !== exp_bz[k]) begin
                bad++;
                $display("FAIL after_reset cyc%0d got tx=%b busy=%b exp tx=%b busy=%b",
                         k, tx1, bz1, exp_tx[k], exp_bz[k]);
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
